// File: rtl/tdc_meas_ctrl_if.sv
// Readout stream of the TDC measurement sequencer: FIFO head record with valid/ready.
// The master (tdc_meas_ctrl) presents m_data/m_valid; the consumer drives m_ready.
interface tdc_meas_ctrl_if #(
  parameter int REC_W = 32
);
  logic [REC_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clears the TDC datapath, arms it, waits for the merging done
// pulse or a timeout, and queues the merged word into a small FIFO drained over valid/ready.
// Optional feature macro: TDC_TIMESTAMP_EN adds a free-running timestamp to each record.
`ifndef DIG_OUT
`define DIG_OUT 32
`endif

module tdc_meas_ctrl #(
  parameter int DATA_W    = `DIG_OUT,
  parameter int FIFO_AW   = 3,
  parameter int RST_CYC   = 2,
  parameter int TIMEOUT_W = 16,
  parameter int TS_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 single,
  input  logic [TIMEOUT_W-1:0] timeout_cyc,
  input  logic                 tdc_done,
  input  logic [DATA_W-1:0]    tdc_out,
  output logic                 tdc_irst,
  tdc_meas_ctrl_if.master      m_if,
  output logic                 busy,
  output logic                 timeout_evt,
  output logic                 fifo_ovf,
  input  logic                 clr_ovf,
  output logic [FIFO_AW:0]     fifo_level
);

`ifdef TDC_TIMESTAMP_EN
  localparam int REC_W = TS_W + DATA_W;
`else
  // TS_W stays referenced so both builds share one parameter list
  localparam int REC_W = DATA_W + 0 * TS_W;
`endif
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LVL_W = FIFO_AW + 1;
  localparam int CLR_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ARMED,
    S_CAPTURE
  } state_t;

  state_t               state_q, state_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [TIMEOUT_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [REC_W-1:0]     rec_q, rec_d;
  logic [REC_W-1:0]     rec_in;
  logic                 push;

  logic [REC_W-1:0]     mem_q [DEPTH];
  logic [REC_W-1:0]     mem_d [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, full, push_ok;

`ifdef TDC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running timestamp, wraps modulo 2**TS_W
  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  // Timestamp register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign rec_in = {ts_q, tdc_out};
`else
  assign rec_in = tdc_out;
`endif

  // Sequencer state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      arm_cnt_q <= '0;
      rec_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      arm_cnt_q <= arm_cnt_d;
      rec_q     <= rec_d;
    end
  end

  // Next state, TDC reset, timeout pulse and capture request
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    arm_cnt_d   = arm_cnt_q;
    rec_d       = rec_q;
    push        = 1'b0;
    timeout_evt = 1'b0;
    tdc_irst    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (en || single) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_W'(RST_CYC - 1)) begin
          state_d   = S_ARMED;
          arm_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      S_ARMED: begin
        tdc_irst  = 1'b0;
        arm_cnt_d = arm_cnt_q + TIMEOUT_W'(1);
        if (tdc_done) begin
          rec_d   = rec_in;
          state_d = S_CAPTURE;
        end else if ((timeout_cyc != '0) &&
                     (arm_cnt_q == timeout_cyc - TIMEOUT_W'(1))) begin
          timeout_evt = 1'b1;
          state_d     = en ? S_CLEAR : S_IDLE;
          clr_cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        push      = 1'b1;
        state_d   = en ? S_CLEAR : S_IDLE;
        clr_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when the head pops in the same cycle
  always_comb begin
    pop      = m_if.m_valid && m_if.m_ready;
    full     = (level_q == LVL_W'(DEPTH));
    push_ok  = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rec_q;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);
    ovf_d = (ovf_q && !clr_ovf) || (push && !push_ok);
  end

  // FIFO storage, pointers, level and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_if.m_data  = mem_q[rd_ptr_q];
  assign m_if.m_valid = (level_q != '0);
  assign busy         = (state_q != S_IDLE);
  assign fifo_ovf     = ovf_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: a measurement-level model (phase + record queue)
// is compared against the DUT every cycle, plus literal checks per directed scenario.
`timescale 1ns/1ps
module tb_tdc_meas_ctrl;
  localparam int DATA_W    = 32;
  localparam int FIFO_AW   = 3;
  localparam int RST_CYC   = 2;
  localparam int TIMEOUT_W = 16;
  localparam int TS_W      = 16;
`ifdef TDC_TIMESTAMP_EN
  localparam int REC_W = TS_W + DATA_W;
`else
  localparam int REC_W = DATA_W;
`endif
  localparam int DEPTH = 1 << FIFO_AW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 single = 1'b0;
  logic                 tdc_done = 1'b0;
  logic                 clr_ovf = 1'b0;
  logic                 m_ready = 1'b0;
  logic [TIMEOUT_W-1:0] timeout_cyc = '0;
  logic [DATA_W-1:0]    tdc_out = '0;
  logic                 tdc_irst, busy, timeout_evt, fifo_ovf;
  logic [FIFO_AW:0]     fifo_level;

  tdc_meas_ctrl_if #(.REC_W(REC_W)) m_if ();
  assign m_if.m_ready = m_ready;

  tdc_meas_ctrl #(
    .DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .RST_CYC(RST_CYC),
    .TIMEOUT_W(TIMEOUT_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .single(single), .timeout_cyc(timeout_cyc),
    .tdc_done(tdc_done), .tdc_out(tdc_out), .tdc_irst(tdc_irst), .m_if(m_if),
    .busy(busy), .timeout_evt(timeout_evt), .fifo_ovf(fifo_ovf), .clr_ovf(clr_ovf),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_CLEAR, P_ARMED, P_CAPTURE} phase_t;
  phase_t           ph = P_IDLE;
  int               clr_left = 0;
  int               armed_n = 0;
  logic [REC_W-1:0] pend = '0;
  logic [REC_W-1:0] q[$];
  logic             ovf_m = 1'b0;
  logic [TS_W-1:0]  ts_m = '0;
  bit               m_pop, m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; clr_left = 0; armed_n = 0; pend = '0;
      q.delete(); ovf_m = 1'b0; ts_m = '0;
    end else begin
      // record queue: head pops first, so a full queue with a pop accepts the capture
      m_pop  = (q.size() != 0) && m_ready;
      m_drop = 1'b0;
      if (m_pop) void'(q.pop_front());
      if (ph == P_CAPTURE) begin
        if (q.size() < DEPTH) q.push_back(pend);
        else m_drop = 1'b1;
      end
      if (clr_ovf) ovf_m = 1'b0;
      if (m_drop)  ovf_m = 1'b1;
      // measurement phases
      case (ph)
        P_IDLE: if (en || single) begin ph = P_CLEAR; clr_left = RST_CYC; end
        P_CLEAR: begin
          clr_left--;
          if (clr_left == 0) begin ph = P_ARMED; armed_n = 0; end
        end
        P_ARMED: begin
          armed_n++;
          if (tdc_done) begin
`ifdef TDC_TIMESTAMP_EN
            pend = {ts_m, tdc_out};
`else
            pend = tdc_out;
`endif
            ph = P_CAPTURE;
          end else if (timeout_cyc != 0 && armed_n == int'(timeout_cyc)) begin
            ph = en ? P_CLEAR : P_IDLE; clr_left = RST_CYC;
          end
        end
        P_CAPTURE: begin ph = en ? P_CLEAR : P_IDLE; clr_left = RST_CYC; end
        default: ph = P_IDLE;
      endcase
      ts_m = ts_m + 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int tq[$];
  logic exp_tmo;

  always @(negedge clk) begin
    cyc++;
    if (timeout_evt === 1'b1) tq.push_back(cyc);
    exp_tmo = (ph == P_ARMED) && !tdc_done && (timeout_cyc != 0) &&
              (armed_n + 1 == int'(timeout_cyc));
    chk("tdc_irst", tdc_irst, ph != P_ARMED);
    chk("busy", busy, ph != P_IDLE);
    chk("timeout_evt", timeout_evt, exp_tmo);
    chk("m_valid", m_if.m_valid, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("fifo_ovf", fifo_ovf, ovf_m);
    if (q.size() != 0) chk("m_data", m_if.m_data, q[0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // single-shot measurement, done on the first ARMED cycle; optional pop during CAPTURE
  task automatic do_meas(input logic [DATA_W-1:0] w, input bit pop_cap);
    single = 1'b1; step(1); single = 1'b0;
    step(RST_CYC);
    tdc_done = 1'b1; tdc_out = w; step(1); tdc_done = 1'b0;
    if (pop_cap) m_ready = 1'b1;
    step(1); m_ready = 1'b0;
  endtask

  int nt0;
  int waited;
  logic [REC_W-1:0] r1, r2;
  logic [TS_W-1:0]  dts;

  initial begin
    step(1);
    chk("rst_irst", tdc_irst, 1); chk("rst_busy", busy, 0);
    chk("rst_valid", m_if.m_valid, 0); chk("rst_level", fifo_level, 0);
    chk("rst_data", m_if.m_data, 0);
    rst_n = 1'b1; step(1);

    // single measurement, done on the 10th ARMED cycle
    single = 1'b1; step(1); single = 1'b0;
    chk("t2_irst_clear", tdc_irst, 1); chk("t2_busy", busy, 1);
    step(2);
    chk("t2_irst_armed", tdc_irst, 0);
    step(9);
    tdc_done = 1'b1; tdc_out = 32'h00A53C01; step(1); tdc_done = 1'b0;
    chk("t2_valid_early", m_if.m_valid, 0);
    step(1);
    chk("t2_valid", m_if.m_valid, 1);
    chk("t2_data", m_if.m_data[DATA_W-1:0], 32'h00A53C01);
    chk("t2_idle", busy, 0);
    m_ready = 1'b1; step(1); m_ready = 1'b0;

    // continuous mode, timeout every 20 ARMED cycles
    timeout_cyc = 16'd20; nt0 = tq.size();
    en = 1'b1; step(70);
    chk("t3_count", 64'(tq.size() - nt0), 3);
    if (tq.size() >= nt0 + 2) chk("t3_period", 64'(tq[nt0+1] - tq[nt0]), 22);
    chk("t3_level", fifo_level, 0);
    en = 1'b0; waited = 0;
    while (busy !== 1'b0 && waited < 60) begin step(1); waited++; end
    chk("t3_idle_wait", busy, 0);

    // done on the timeout cycle wins
    timeout_cyc = 16'd5; nt0 = tq.size();
    single = 1'b1; step(1); single = 1'b0;
    step(6);
    tdc_done = 1'b1; tdc_out = 32'h5; step(1); tdc_done = 1'b0;
    step(1);
    chk("t5_level", fifo_level, 1); chk("t5_no_tmo", 64'(tq.size() - nt0), 0);
    chk("t5_data", m_if.m_data[DATA_W-1:0], 32'h5);
    m_ready = 1'b1; step(1); m_ready = 1'b0;

    // overflow: nine captures into eight slots
    timeout_cyc = '0;
    for (int i = 1; i <= 9; i++) do_meas(DATA_W'(i), 1'b0);
    chk("t4_level", fifo_level, 8); chk("t4_ovf", fifo_ovf, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t4_drain", m_if.m_data[DATA_W-1:0], i);
      m_ready = 1'b1; step(1); m_ready = 1'b0;
    end
    chk("t4_empty", fifo_level, 0);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    chk("t4_clr", fifo_ovf, 0);

    // full FIFO with a same-cycle pop accepts the capture
    for (int i = 1; i <= 8; i++) do_meas(DATA_W'(100 + i), 1'b0);
    do_meas(DATA_W'(200), 1'b1);
    chk("tf_level", fifo_level, 8); chk("tf_ovf", fifo_ovf, 0);
    chk("tf_head", m_if.m_data[DATA_W-1:0], 102);
    m_ready = 1'b1; step(8); m_ready = 1'b0;
    chk("tf_empty", fifo_level, 0);

    // reset mid-ARMED with three records queued
    for (int i = 1; i <= 3; i++) do_meas(DATA_W'(i), 1'b0);
    en = 1'b1; step(4);
    chk("t1_armed", tdc_irst, 0);
    rst_n = 1'b0; step(1);
    chk("t1_irst", tdc_irst, 1); chk("t1_busy", busy, 0);
    chk("t1_valid", m_if.m_valid, 0); chk("t1_level", fifo_level, 0);
    chk("t1_ovf", fifo_ovf, 0);
    en = 1'b0; rst_n = 1'b1; step(1);

`ifdef TDC_TIMESTAMP_EN
    // two dones 37 cycles apart
    en = 1'b1; step(3);
    tdc_done = 1'b1; tdc_out = 32'h11; step(1); tdc_done = 1'b0;
    step(36);
    tdc_done = 1'b1; tdc_out = 32'h22; step(1); tdc_done = 1'b0; en = 1'b0;
    step(2);
    chk("t6_level", fifo_level, 2);
    r1 = m_if.m_data; m_ready = 1'b1; step(1); m_ready = 1'b0;
    r2 = m_if.m_data; m_ready = 1'b1; step(1); m_ready = 1'b0;
    dts = r2[REC_W-1:DATA_W] - r1[REC_W-1:DATA_W];
    chk("t6_ts_delta", dts, 37);
    chk("t6_word", r2[DATA_W-1:0], 32'h22);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
